// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage: RV32I ALU opcode decode and operand registers
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VALID_IN,
    input  logic [31:0]     INSTRUCTION,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [XLEN-1:0] RS2_DATA,
    input  logic [XLEN-1:0] PC,
    input  logic            STALL,
    input  logic            FLUSH,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      OPERATION,
    output logic            VALID_OUT,
    output logic            ILLEGAL
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_PASS = 4'b1111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            f7b;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    logic [XLEN-1:0] a_d, a_q;
    logic [XLEN-1:0] b_d, b_q;
    logic [3:0]      op_d, op_q;
    logic            valid_d, valid_q;
    logic            illegal_d, illegal_q;

    assign opcode = INSTRUCTION[6:0];
    assign f3     = INSTRUCTION[14:12];
    assign f7b    = INSTRUCTION[30];
    assign imm_i  = {{(XLEN-12){INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign imm_s  = {{(XLEN-12){INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign imm_u  = {INSTRUCTION[31:12], 12'b0};
    assign shamt  = {{(XLEN-5){1'b0}}, INSTRUCTION[24:20]};

    // Decode the instruction into operands and ALU op; VALID_IN low yields a bubble
    always_comb begin
        a_d       = '0;
        b_d       = '0;
        op_d      = OP_AND;
        valid_d   = VALID_IN;
        illegal_d = 1'b0;
        if (VALID_IN) begin
            unique case (opcode)
                OPC_R, OPC_I: begin
                    a_d = RS1_DATA;
                    b_d = (opcode == OPC_R) ? RS2_DATA : imm_i;
                    unique case (f3)
                        3'b000: op_d = (opcode == OPC_R && f7b) ? OP_SUB : OP_ADD;
                        3'b001: op_d = OP_SLL;
                        3'b010: op_d = OP_SLT;
                        3'b011: op_d = OP_SLTU;
                        3'b100: op_d = OP_XOR;
                        3'b101: op_d = f7b ? OP_SRA : OP_SRL;
                        3'b110: op_d = OP_OR;
                        default: op_d = OP_AND;
                    endcase
                    // Immediate shifts take only the 5-bit shamt, not the funct7 bits
                    if (opcode == OPC_I && (f3 == 3'b001 || f3 == 3'b101))
                        b_d = shamt;
                end
                OPC_LOAD: begin
                    op_d = OP_ADD;
                    a_d  = RS1_DATA;
                    b_d  = imm_i;
                end
                OPC_STORE: begin
                    op_d = OP_ADD;
                    a_d  = RS1_DATA;
                    b_d  = imm_s;
                end
                OPC_BRANCH: begin
                    if (f3[2:1] == 2'b01) begin
                        illegal_d = 1'b1;
                    end else begin
                        a_d = RS1_DATA;
                        b_d = RS2_DATA;
                        unique case (f3[2:1])
                            2'b00:   op_d = OP_SUB;
                            2'b10:   op_d = OP_SLT;
                            default: op_d = OP_SLTU;
                        endcase
                    end
                end
                OPC_LUI: begin
                    op_d = OP_PASS;
                    b_d  = imm_u;
                end
                OPC_AUIPC: begin
                    op_d = OP_ADD;
                    a_d  = PC;
                    b_d  = imm_u;
                end
                OPC_JAL, OPC_JALR: begin
                    op_d = OP_ADD;
                    a_d  = PC;
                    b_d  = XLEN'(4);
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    // Output registers with priority reset > flush > stall > load
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!STALL) begin
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign OPERATION = op_q;
    assign VALID_OUT = valid_q;
    assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VALID_IN;
    logic [31:0] INSTRUCTION;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic [31:0] PC;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  OPERATION;
    logic        VALID_OUT;
    logic        ILLEGAL;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        v;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_issue_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .INSTRUCTION(INSTRUCTION),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .PC(PC), .STALL(STALL),
        .FLUSH(FLUSH), .A(A), .B(B), .OPERATION(OPERATION),
        .VALID_OUT(VALID_OUT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_outputs();
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        assert (A === e.a) else begin
            n_err++;
            $error("FAIL %s.A observed=%h expected=%h", e.tag, A, e.a);
        end
        n_vec++;
        assert (B === e.b) else begin
            n_err++;
            $error("FAIL %s.B observed=%h expected=%h", e.tag, B, e.b);
        end
        n_vec++;
        assert (OPERATION === e.op) else begin
            n_err++;
            $error("FAIL %s.OPERATION observed=%b expected=%b", e.tag, OPERATION, e.op);
        end
        n_vec++;
        assert (VALID_OUT === e.v) else begin
            n_err++;
            $error("FAIL %s.VALID_OUT observed=%b expected=%b", e.tag, VALID_OUT, e.v);
        end
        n_vec++;
        assert (ILLEGAL === e.ill) else begin
            n_err++;
            $error("FAIL %s.ILLEGAL observed=%b expected=%b", e.tag, ILLEGAL, e.ill);
        end
    endtask

    // Drive one cycle of stimulus, record its expected outcome, check after the edge
    task automatic step(input string tag, input logic rst, input logic flush,
                        input logic stall, input logic vin, input logic [31:0] instr,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] eop,
                        input logic ev, input logic eill);
        exp_t e;
        RST = rst; FLUSH = flush; STALL = stall; VALID_IN = vin;
        INSTRUCTION = instr; RS1_DATA = rs1; RS2_DATA = rs2; PC = pc;
        e.tag = tag; e.a = ea; e.b = eb; e.op = eop; e.v = ev; e.ill = eill;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; VALID_IN = 1'b1;
        INSTRUCTION = 32'h003100B3; RS1_DATA = 32'hEC; RS2_DATA = 32'h258; PC = 32'h0;
        @(negedge CLK);

        // Reset held two cycles with a valid ADD presented
        step("rst0", 1, 0, 0, 1, 32'h003100B3, 32'hEC, 32'h258, 0, 0, 0, 4'b0000, 0, 0);
        step("rst1", 1, 0, 0, 1, 32'h003100B3, 32'hEC, 32'h258, 0, 0, 0, 4'b0000, 0, 0);
        step("post_rst_add", 0, 0, 0, 1, 32'h003100B3, 32'hEC, 32'h258, 0, 32'hEC, 32'h258, 4'b0010, 1, 0);

        // R-type
        step("r_sub",  0, 0, 0, 1, 32'h403100B3, 32'hEC, 32'h258, 0, 32'hEC, 32'h258, 4'b0110, 1, 0);
        step("r_sltu", 0, 0, 0, 1, 32'h003130B3, 32'h11, 32'h22, 0, 32'h11, 32'h22, 4'b1000, 1, 0);

        // Immediates
        step("i_addi_neg", 0, 0, 0, 1, 32'hFFF10093, 32'h33, 32'h44, 0, 32'h33, 32'hFFFFFFFF, 4'b0010, 1, 0);
        step("i_srai",     0, 0, 0, 1, 32'h40515093, 32'h80000000, 32'h44, 0, 32'h80000000, 32'h5, 4'b1101, 1, 0);
        step("lui",        0, 0, 0, 1, 32'h123450B7, 32'h55, 32'h66, 0, 32'h0, 32'h12345000, 4'b1111, 1, 0);
        step("store_sw",   0, 0, 0, 1, 32'hFE112E23, 32'h1000, 32'h77, 0, 32'h1000, 32'hFFFFFFFC, 4'b0010, 1, 0);

        // PC-relative
        step("jal",   0, 0, 0, 1, 32'h0000006F, 32'h9, 32'h9, 32'h100, 32'h100, 32'h4, 4'b0010, 1, 0);
        step("auipc", 0, 0, 0, 1, 32'h00001017, 32'h9, 32'h9, 32'h200, 32'h200, 32'h1000, 4'b0010, 1, 0);

        // Branches
        step("beq",  0, 0, 0, 1, 32'h00208063, 32'h3, 32'h4, 0, 32'h3, 32'h4, 4'b0110, 1, 0);
        step("bltu", 0, 0, 0, 1, 32'h00006063, 32'h5, 32'h6, 0, 32'h5, 32'h6, 4'b1000, 1, 0);

        // Stall holds the last ADD while SUB is presented
        step("load_add", 0, 0, 0, 1, 32'h003100B3, 32'h1, 32'h2, 0, 32'h1, 32'h2, 4'b0010, 1, 0);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 0, 0, 1, 1, 32'h403100B3, 32'h7, 32'h9, 0, 32'h1, 32'h2, 4'b0010, 1, 0);
        step("stall_flush", 0, 1, 1, 1, 32'h403100B3, 32'h7, 32'h9, 0, 0, 0, 4'b0000, 0, 0);

        // Flush discards a resident instruction
        step("load_add2", 0, 0, 0, 1, 32'h003100B3, 32'hA, 32'hB, 0, 32'hA, 32'hB, 4'b0010, 1, 0);
        step("flush",     0, 1, 0, 1, 32'h003100B3, 32'hA, 32'hB, 0, 0, 0, 4'b0000, 0, 0);

        // Illegal and bubble
        step("illegal_ones", 0, 0, 0, 1, 32'hFFFFFFFF, 32'h12, 32'h34, 0, 0, 0, 4'b0000, 1, 1);
        step("illegal_br",   0, 0, 0, 1, 32'h00002063, 32'h12, 32'h34, 0, 0, 0, 4'b0000, 1, 1);
        step("bubble",       0, 0, 0, 0, 32'h003100B3, 32'h12, 32'h34, 0, 0, 0, 4'b0000, 0, 0);

        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
